// File: rtl/frame_write_controller.sv
// Write side of the VGA frame buffer: aligns a valid/ready raster stream to
// start-of-frame and drives the frame RAM write port one cycle after acceptance.
module frame_write_controller #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            frame_count,
  output logic                  sof_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(H_PIXELS * V_LINES - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   index_q, index_d;
  logic                    wr_enable_q, wr_enable_d;
  logic [ADDR_WIDTH-1:0]   wr_address_q, wr_address_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [7:0]              frame_count_q, frame_count_d;
  logic                    sof_error_q, sof_error_d;

  logic                    accept;
  logic                    do_write;
  logic [ADDR_WIDTH-1:0]   write_index;

  // Ready depends only on the registered state, so there is no input-to-output path.
  assign pix_ready  = (state_q == WAIT_SOF) || (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign accept     = pix_valid & pix_ready;

  assign wr_enable   = wr_enable_q;
  assign wr_address  = wr_address_q;
  assign wr_data     = wr_data_q;
  assign frame_count = frame_count_q;
  assign sof_error   = sof_error_q;

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    wr_enable_d   = 1'b0;
    wr_address_d  = wr_address_q;
    wr_data_d     = wr_data_q;
    frame_count_d = frame_count_q;
    sof_error_d   = sof_error_q;
    do_write      = 1'b0;
    // An SOF beat always restarts the frame at pixel 0, also inside WRITE.
    write_index   = pix_sof ? '0 : index_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT_SOF;
          sof_error_d = 1'b0;
        end
      end
      WAIT_SOF: begin
        do_write = accept & pix_sof;
      end
      WRITE: begin
        do_write = accept;
        if (accept && pix_sof) begin
          sof_error_d = 1'b1;
        end
      end
      DONE: begin
        state_d = continuous ? WAIT_SOF : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_write) begin
      wr_enable_d  = 1'b1;
      wr_address_d = write_index;
      wr_data_d    = pix_data;
      if (write_index == LAST_INDEX) begin
        state_d       = DONE;
        index_d       = '0;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        state_d = WRITE;
        index_d = write_index + ADDR_WIDTH'(1);
      end
    end

    // Abort overrides start, acceptance and frame completion alike.
    if (abort) begin
      state_d       = IDLE;
      index_d       = '0;
      wr_enable_d   = 1'b0;
      wr_address_d  = wr_address_q;
      wr_data_d     = wr_data_q;
      frame_count_d = frame_count_q;
      sof_error_d   = sof_error_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      wr_enable_q   <= 1'b0;
      wr_address_q  <= '0;
      wr_data_q     <= '0;
      frame_count_q <= 8'd0;
      sof_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      wr_enable_q   <= wr_enable_d;
      wr_address_q  <= wr_address_d;
      wr_data_q     <= wr_data_d;
      frame_count_q <= frame_count_d;
      sof_error_q   <= sof_error_d;
    end
  end

endmodule

// File: doc/frame_write_controller.md
Name: frame_write_controller

Overview:
- Write side of the frame buffer that the VGA scan-out path reads from.
- Accepts a raster pixel stream from the capture/Sobel pipeline using a valid/ready handshake.
- Aligns the stream to start-of-frame and generates write address, write data and write enable for the dual-port frame RAM.
- Tracks completed frames and flags stream misalignment.

Parameters:
H_PIXELS, 640, active pixels per line
V_LINES, 480, active lines per frame
ADDR_WIDTH, 20, frame RAM address width; must satisfy 2^ADDR_WIDTH >= H_PIXELS*V_LINES
DATA_WIDTH, 8, pixel width

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
start  input  1  arm capture; sampled only in IDLE
continuous  input  1  1 = re-arm automatically after each frame; sampled in DONE
abort  input  1  synchronous abort of any capture; return to IDLE
pix_valid  input  1  pixel beat valid
pix_sof  input  1  beat is first pixel of a frame; qualified by pix_valid
pix_data  input  DATA_WIDTH  pixel value
pix_ready  output  1  controller accepts the beat this cycle
wr_enable  output  1  frame RAM write strobe
wr_address  output  ADDR_WIDTH  frame RAM write address
wr_data  output  DATA_WIDTH  frame RAM write data
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse when a full frame has been written
frame_count  output  8  completed frames, wraps 255 -> 0
sof_error  output  1  sticky; set on pix_sof inside a frame; cleared by start in IDLE or by reset

Behaviour:
- Reset (reset=0, async): state IDLE; internal pixel index 0.
  - All outputs 0: pix_ready, wr_enable, wr_address, wr_data, frame_done, frame_count, sof_error, busy.
- Accept condition: a beat is accepted when pix_valid & pix_ready. pix_ready is a combinational function of state only, with no input-to-output path.
- States:
  - IDLE:
    - pix_ready=0.
    - start=1 moves to WAIT_SOF next cycle and clears sof_error.
  - WAIT_SOF:
    - pix_ready=1.
    - An accepted beat with pix_sof=0 is discarded: no write.
    - An accepted beat with pix_sof=1 is written at index 0 and moves to WRITE with index 1.
  - WRITE:
    - pix_ready=1.
    - Each accepted beat is written at the current index, then the index increments.
    - An accepted beat with pix_sof=1 sets sof_error, is written at index 0 (resync), and the index becomes 1.
    - An accepted beat at index H_PIXELS*V_LINES-1 is written, then the state moves to DONE and the index resets to 0.
    - Cycles with pix_valid=0 hold all state.
  - DONE:
    - Lasts exactly one cycle; pix_ready=0.
    - frame_done=1 and frame_count increments in this cycle.
    - Next state is WAIT_SOF if continuous=1, else IDLE.
- Write port latency is 1 cycle.
  - For a beat accepted at edge N, wr_enable=1, wr_address=index and wr_data=pix_data are registered and visible after edge N.
  - wr_enable is 0 in every cycle that follows no accepted write.
  - wr_address and wr_data hold their last values when wr_enable=0.
- Because of this latency, the write of the last pixel is visible in the same cycle that DONE is active with frame_done=1.
- abort=1 in any state:
  - Next state is IDLE and the index returns to 0.
  - A beat presented in the abort cycle is not written.
  - frame_count is unchanged.
  - abort has priority over start and over pixel acceptance.
- start while not in IDLE is ignored.
- Arithmetic:
  - The index compares against the constant H_PIXELS*V_LINES-1 computed at ADDR_WIDTH width.
  - The index never exceeds that value.
  - frame_count is an 8-bit modulo-256 counter.
- A partially written frame, whether aborted or resynced, does not pulse frame_done.

Test Plan:
- Reset and idle (H_PIXELS=4, V_LINES=3): assert reset mid-run, then drive pix_valid=1 with no start. Expect all outputs 0, no wr_enable, pix_ready=0.
- Single frame (continuous=0):
  - Pulse start, send 2 non-SOF beats, then 12 beats with SOF on the first and data 0x10..0x1B.
  - Expect exactly 12 writes at addresses 0..11 with matching data, each one cycle after acceptance.
  - Expect frame_done pulsed once, frame_count=1, return to IDLE.
- Stalls (same setup): toggle pix_valid randomly during the frame. Expect addresses remain contiguous with no duplicate writes, and frame_done only after the 12th accepted beat.
- Resync: send SOF, 5 beats, then SOF again followed by 11 beats. Expect sof_error=1, the second SOF written at address 0, and frame_done after address 11. Then start in IDLE clears sof_error.
- Continuous and wrap:
  - With continuous=1, stream 257 full frames.
  - Expect frame_count to wrap to 1 and no IDLE visits.
  - Expect DONE to last one cycle each frame, with pix_ready=0 in that cycle.
- Abort: assert abort with start and pix_valid in the same cycle at index 7. Expect no write that cycle, IDLE next, frame_count unchanged, and the next frame starting from address 0.
